// File: rtl/ex_mem_skid.sv
// Execute-to-memory pipeline register with a 2-entry skid buffer and registered pcSrc.
// Optional EX_MEM_STATS_EN adds acceptCount/stallCount output ports.
module ex_mem_skid #(
  parameter int Nbits   = 64,
  parameter int RegBits = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [Nbits-1:0]   aluResult,
  input  logic               zero,
  input  logic [Nbits-1:0]   storeData,
  input  logic [RegBits-1:0] rd,
  input  logic               regWrite,
  input  logic               memRead,
  input  logic               memWrite,
  input  logic               branch,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [Nbits-1:0]   out_aluResult,
  output logic               out_zero,
  output logic [Nbits-1:0]   out_storeData,
  output logic [RegBits-1:0] out_rd,
  output logic               out_regWrite,
  output logic               out_memRead,
  output logic               out_memWrite,
  output logic               pcSrc
`ifdef EX_MEM_STATS_EN
  ,
  output logic [31:0]        acceptCount,
  output logic [31:0]        stallCount
`endif
);

  typedef struct packed {
    logic [Nbits-1:0]   alu;
    logic               zero;
    logic [Nbits-1:0]   sd;
    logic [RegBits-1:0] rd;
    logic               rw;
    logic               mr;
    logic               mw;
    logic               br;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t state_q, state_d;
  entry_t main_q, main_d, skid_q, skid_d, in_entry;
  logic   accept, pop;

  always_comb begin
    in_entry.alu  = aluResult;
    in_entry.zero = zero;
    in_entry.sd   = storeData;
    in_entry.rd   = rd;
    in_entry.rw   = regWrite;
    in_entry.mr   = memRead;
    in_entry.mw   = memWrite;
    in_entry.br   = branch;
  end

  // in_ready depends only on registered state, never on out_ready.
  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_d  = in_entry;
            state_d = ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_d = in_entry;
          end else if (accept) begin
            skid_d  = in_entry;
            state_d = TWO;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign out_aluResult = main_q.alu;
  assign out_zero      = main_q.zero;
  assign out_storeData = main_q.sd;
  assign out_rd        = main_q.rd;
  assign out_regWrite  = main_q.rw;
  assign out_memRead   = main_q.mr;
  assign out_memWrite  = main_q.mw;
  assign pcSrc         = out_valid & main_q.br & main_q.zero;

`ifdef EX_MEM_STATS_EN
  logic [31:0] accept_cnt_q, stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      accept_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      if (accept)                 accept_cnt_q <= accept_cnt_q + 32'd1;
      if (out_valid && !out_ready) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign acceptCount = accept_cnt_q;
  assign stallCount  = stall_cnt_q;
`endif

endmodule

// File: doc/ex_mem_skid.md
Name: ex_mem_skid

Overview:
- Registered execute-to-memory boundary stage. Sits directly downstream of the 64-bit ALU in the RISC-V datapath.
- Captures the ALU result and zero flag together with the control bits and store data that travel alongside them.
- Presents these to the memory stage through a valid/ready handshake.
- A 2-entry skid buffer lets a memory-stage stall back-pressure the execute stage without losing an in-flight result.
- Computes the registered branch-taken signal pcSrc.

Parameters:
- Nbits, 64, datapath width of aluResult and storeData
- RegBits, 5, destination register index width

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- flush  input  1  synchronous pipeline flush; discards all held entries
- in_valid  input  1  execute stage presents a valid entry
- in_ready  output  1  stage can accept an entry this cycle
- aluResult  input  Nbits  result from ALU
- zero  input  1  ALU zero flag
- storeData  input  Nbits  rs2 data for stores
- rd  input  RegBits  destination register
- regWrite, memRead, memWrite, branch  input  1 each  control bits
- out_valid  output  1  head entry valid toward memory stage
- out_ready  input  1  memory stage consumes head entry this cycle
- out_aluResult  output  Nbits  head entry aluResult
- out_zero  output  1  head entry zero
- out_storeData  output  Nbits  head entry storeData
- out_rd  output  RegBits  head entry rd
- out_regWrite, out_memRead, out_memWrite  output  1 each  head entry control bits
- pcSrc  output  1  head entry branch AND zero, qualified by out_valid

Behaviour:
- Storage: a main register (head, drives out_*) plus a skid register, each with its own valid bit.
- States:
  - EMPTY: neither entry valid.
  - ONE: main valid.
  - TWO: main and skid valid.
- in_ready is driven from registered state only: in_ready = not skid_valid. It is 1 in EMPTY and ONE, 0 in TWO. There is no combinational path from out_ready to in_ready.
- Handshake terms:
  - accept = in_valid AND in_ready
  - pop = out_valid AND out_ready
- Transitions:
  - EMPTY: accept loads main, next state ONE.
  - ONE, accept without pop: load skid, go to TWO.
  - ONE, pop without accept: go to EMPTY.
  - ONE, accept with pop: load main with the new entry, stay in ONE.
  - TWO, pop: skid moves to main, go to ONE. No accept is possible because in_ready is 0.
  - TWO, no pop: hold everything.
- Latency:
  - An entry accepted at edge N appears on out_* with out_valid=1 after edge N.
  - Entries leave in strict FIFO order; none are dropped or duplicated.
- pcSrc = out_valid AND head.branch AND head.zero. It is derived from registered head fields, never from the live inputs.
- out_* data holds its value while out_valid=1 and out_ready=0. The memory stage may sample it on any cycle.
- Fields of an invalid entry are don't-care for the consumer. Implementation holds the last values.
- flush:
  - At the next edge both valid bits clear and the state goes to EMPTY.
  - An in_valid entry presented in the flush cycle is discarded.
  - out_ready in the flush cycle has no effect.
- reset:
  - Has priority over flush and over the handshake.
  - At the next edge both valid bits are 0, all data and control registers are 0, and any optional counters are 0.
- Reset values: out_valid=0, in_ready=1 (after reset), pcSrc=0, all out_* fields=0.
- Reset asserted mid-transfer in state TWO drops both entries; no partial state survives.

Optional Feature:
- Macro EX_MEM_STATS_EN.
- When defined, adds two output ports:
  - acceptCount [31:0]: increments on every accept.
  - stallCount [31:0]: increments on every cycle with out_valid=1 and out_ready=0.
- Both counters wrap from 32'hFFFFFFFF to 0, clear on reset, and are not cleared by flush.
- When undefined, the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then single entry:
  - Stimulus: reset=1 for 2 cycles; then one entry with aluResult=64'h10, zero=0, rd=5, regWrite=1, with out_ready=1.
  - Required: out_valid=1 for exactly one cycle after acceptance, out_aluResult=64'h10, out_rd=5, pcSrc=0; state returns to EMPTY.
- Back-pressure fill:
  - Stimulus: out_ready=0; entries A (aluResult=1), B (aluResult=2), C (aluResult=3) presented back-to-back.
  - Required: A and B accepted, in_ready=0 the cycle after B and C held at input.
  - Then out_ready=1: outputs 1, 2, 3 in order, each for one cycle.
- Streaming:
  - Stimulus: in_valid=1 and out_ready=1 continuously for 8 entries, aluResult=0..7.
  - Required: one entry out per cycle, no bubbles after the first, state stays ONE.
- Branch:
  - Stimulus: entry with branch=1, aluResult=0, zero=1.
  - Required: pcSrc=1 while that entry is head; a following entry with zero=0 gives pcSrc=0.
- Flush in TWO:
  - Stimulus: fill two entries with out_ready=0, then assert flush together with a new in_valid entry.
  - Required: next cycle out_valid=0, in_ready=1, and the new entry never appears on out_*.
- Stats (EX_MEM_STATS_EN defined):
  - Stimulus: 3 accepts, 4 stalled cycles, then flush.
  - Required: acceptCount=3, stallCount=4, both unchanged by the flush; reset sets both to 0.
